// File: rtl/mult_arb_pkg.sv
// Shared constants and helpers for the multiplier arbiter.
// Holds the multiplier latency, the default requester ID width and a constant clog2.
package mult_arb_pkg;

    localparam int MULT_LAT = 2;
    localparam int ID_W_DEF = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_arb_rr_pick.sv
// Round-robin picker: the first set request at or after the pointer, searching upward
// and wrapping from NREQ-1 back to 0.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [ID_W-1:0] o_idx,
    output logic            o_any
);

    always_comb begin
        int j;
        j     = 0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(i_ptr) + i) % NREQ;
            if (!o_any && i_req[j]) begin
                o_any    = 1'b1;
                o_idx    = ID_W'(j);
                o_gnt[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arb.sv
// Round-robin sequencer sharing one pipelined signed 8x8 multiplier among NREQ clients.
// Each requester ID travels through a tag pipeline that matches the multiplier latency.
module mult_arb #(
    parameter int NREQ     = 4,
    parameter int ID_W     = mult_arb_pkg::ID_W_DEF,
    parameter int MULT_LAT = mult_arb_pkg::MULT_LAT
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NREQ-1:0]                              req_valid,
    input  logic [NREQ*8-1:0]                            req_a,
    input  logic [NREQ*8-1:0]                            req_b,
    output logic [NREQ-1:0]                              req_ready,
    input  logic                                         hold,
    output logic [7:0]                                   mult_a,
    output logic [7:0]                                   mult_b,
    input  logic [15:0]                                  mult_p,
    output logic                                         res_valid,
    output logic [ID_W-1:0]                              res_id,
    output logic [15:0]                                  res_p,
    output logic [mult_arb_pkg::clog2(MULT_LAT+1)-1:0]   inflight,
    output logic [15:0]                                  issue_cnt
);

    import mult_arb_pkg::*;

    localparam int INF_W = clog2(MULT_LAT + 1);

    logic [NREQ-1:0]     w_gnt;
    logic [ID_W-1:0]     w_idx;
    logic                w_any;
    logic                w_accept;

    logic [ID_W-1:0]     r_ptr;
    logic [MULT_LAT-1:0] r_tag_vld;
    logic [ID_W-1:0]     r_tag_id [MULT_LAT];
    logic [INF_W-1:0]    r_inflight;
    logic [15:0]         r_issue_cnt;

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_accept  = w_any & ~hold & ~rst;
    assign req_ready = w_accept ? w_gnt : '0;
    assign mult_a    = w_accept ? req_a[8*w_idx +: 8] : 8'h00;
    assign mult_b    = w_accept ? req_b[8*w_idx +: 8] : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_tag_vld   <= '0;
            r_inflight  <= '0;
            r_issue_cnt <= '0;
            for (int i = 0; i < MULT_LAT; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_vld[0] <= w_accept;
            r_tag_id[0]  <= w_idx;
            for (int i = 1; i < MULT_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
            if (w_accept) begin
                r_ptr       <= (w_idx == ID_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;
                r_issue_cnt <= r_issue_cnt + 16'd1;
            end
            // Simultaneous issue and return leave the count unchanged.
            case ({w_accept, res_valid})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Product arrives in the same cycle as its tag reaches the last stage.
    assign res_valid = r_tag_vld[MULT_LAT-1];
    assign res_id    = r_tag_id[MULT_LAT-1];
    assign res_p     = res_valid ? mult_p : 16'h0000;
    assign inflight  = r_inflight;
    assign issue_cnt = r_issue_cnt;

endmodule

// File: tb/tb_mult_arb.sv
// Self-checking bench for mult_arb: a two-register multiplier model, a cycle model of the
// arbiter and a result scoreboard, plus directed checks on signed corners and counters.
module tb_mult_arb;

    localparam int NREQ = 4;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] p;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        hold;
    logic [7:0]  mult_a;
    logic [7:0]  mult_b;
    logic [15:0] mult_p;
    logic        res_valid;
    logic [1:0]  res_id;
    logic [15:0] res_p;
    logic [1:0]  inflight;
    logic [15:0] issue_cnt;

    int n_checks = 0;
    int n_errors = 0;

    res_t        sb_q[$];
    res_t        res_log[$];
    logic [15:0] last_p  = '0;
    logic [1:0]  last_id = '0;

    logic [1:0]  m_ptr      = '0;
    logic [1:0]  m_vld      = '0;
    logic [1:0]  m_inflight = '0;
    logic [15:0] m_cnt      = '0;

    always #5 clk = ~clk;

    mult_arb #(
        .NREQ     (4),
        .ID_W     (2),
        .MULT_LAT (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .hold      (hold),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_p    (mult_p),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_p     (res_p),
        .inflight  (inflight),
        .issue_cnt (issue_cnt)
    );

    // Multiplier model: operand register then product register.
    logic [7:0]  r_ma = '0;
    logic [7:0]  r_mb = '0;
    logic [15:0] r_mp = '0;
    always @(posedge clk) begin
        r_ma <= mult_a;
        r_mb <= mult_b;
        r_mp <= {{8{r_ma[7]}}, r_ma} * {{8{r_mb[7]}}, r_mb};
    end
    assign mult_p = r_mp;

    function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
        return {{8{a[7]}}, a} * {{8{b[7]}}, b};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    // Cycle model, evaluated mid-cycle once inputs are settled.
    always @(negedge clk) begin
        logic [3:0]  exp_ready;
        logic [1:0]  exp_g;
        logic        found;
        int          j;
        res_t        r;
        if (rst) begin
            check_eq("rst_ready", req_ready, 0);
            check_eq("rst_res_valid", res_valid, 0);
            check_eq("rst_inflight", inflight, 0);
            check_eq("rst_issue_cnt", issue_cnt, 0);
            check_eq("rst_mult_a", mult_a, 0);
            m_ptr      = '0;
            m_vld      = '0;
            m_inflight = '0;
            m_cnt      = '0;
            sb_q.delete();
        end else begin
            exp_ready = '0;
            exp_g     = '0;
            found     = 1'b0;
            if (!hold) begin
                for (int i = 0; i < NREQ; i++) begin
                    j = (int'(m_ptr) + i) % NREQ;
                    if (!found && req_valid[j]) begin
                        found        = 1'b1;
                        exp_g        = 2'(j);
                        exp_ready[j] = 1'b1;
                    end
                end
            end
            check_eq("ready", req_ready, exp_ready);
            check_eq("res_valid", res_valid, m_vld[1]);
            check_eq("inflight", inflight, m_inflight);
            check_eq("issue_cnt", issue_cnt, m_cnt);
            if (res_valid) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_nonempty", 0, 1);
                end else begin
                    r = sb_q.pop_front();
                    check_eq("res_id", res_id, r.id);
                    check_eq("res_p", res_p, r.p);
                end
                last_p  = res_p;
                last_id = res_id;
                res_log.push_back({res_id, res_p});
            end else begin
                check_eq("res_p_idle", res_p, 0);
            end
            if (found) begin
                check_eq("mult_a", mult_a, req_a[8*exp_g +: 8]);
                check_eq("mult_b", mult_b, req_b[8*exp_g +: 8]);
                sb_q.push_back({exp_g, smul(req_a[8*exp_g +: 8], req_b[8*exp_g +: 8])});
                m_cnt = m_cnt + 16'd1;
                m_ptr = exp_g + 2'd1;
            end else begin
                check_eq("mult_a_idle", mult_a, 0);
            end
            if (found && !m_vld[1]) m_inflight = m_inflight + 2'd1;
            else if (!found && m_vld[1]) m_inflight = m_inflight - 2'd1;
            m_vld = {m_vld[0], found};
        end
    end

    logic [7:0]  corner_a [3] = '{8'h80, 8'h80, 8'hFF};
    logic [7:0]  corner_b [3] = '{8'h80, 8'h7F, 8'h01};
    logic [15:0] corner_p [3] = '{16'h4000, 16'hC080, 16'hFFFF};

    initial begin
        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (2) step();
        rst = 1'b0;

        // Single op on the first cycle after reset.
        req_a[7:0] = 8'h7F;
        req_b[7:0] = 8'h7F;
        req_valid  = 4'b0001;
        #1;
        check_eq("single_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        repeat (4) step();
        check_eq("single_p", last_p, 16'h3F01);
        check_eq("single_id", last_id, 0);
        check_eq("single_inflight", inflight, 0);

        // Signed corners from requester 2.
        for (int k = 0; k < 3; k++) begin
            req_a[23:16] = corner_a[k];
            req_b[23:16] = corner_b[k];
            req_valid    = 4'b0100;
            step();
            req_valid = '0;
            repeat (3) step();
            check_eq("corner_p", last_p, corner_p[k]);
            check_eq("corner_id", last_id, 2);
        end

        // Round robin with all four requesting.
        reset_dut();
        res_log.delete();
        for (int i = 0; i < NREQ; i++) begin
            req_a[8*i +: 8] = 8'(i + 1);
            req_b[8*i +: 8] = 8'd2;
        end
        req_valid = 4'b1111;
        repeat (3) step();
        check_eq("rr_inflight_steady", inflight, 2);
        repeat (5) step();
        req_valid = '0;
        check_eq("rr_issue_cnt", issue_cnt, 8);
        repeat (4) step();
        check_eq("rr_count", res_log.size(), 8);
        for (int i = 0; i < res_log.size(); i++) begin
            check_eq("rr_id", res_log[i].id, i % 4);
            check_eq("rr_p", res_log[i].p, 2 * (i % 4 + 1));
        end

        // Hold for three cycles after the second grant.
        reset_dut();
        res_log.delete();
        req_valid = 4'b1111;
        repeat (2) step();
        hold = 1'b1;
        #1;
        check_eq("hold_ready", req_ready, 0);
        repeat (3) step();
        hold = 1'b0;
        #1;
        check_eq("hold_resume", req_ready, 4'b0100);
        step();
        req_valid = '0;
        repeat (4) step();
        check_eq("hold_issue_cnt", issue_cnt, 3);
        check_eq("hold_results", res_log.size(), 3);

        // Reset with two ops in flight.
        reset_dut();
        res_log.delete();
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        rst       = 1'b1;
        repeat (2) step();
        check_eq("mid_inflight", inflight, 0);
        check_eq("mid_issue_cnt", issue_cnt, 0);
        rst = 1'b0;
        repeat (3) step();
        check_eq("mid_no_result", res_log.size(), 0);
        req_a[31:24] = 8'hFE;
        req_b[31:24] = 8'h03;
        req_valid    = 4'b1000;
        step();
        req_valid = '0;
        repeat (4) step();
        check_eq("mid_new_p", last_p, 16'hFFFA);
        check_eq("mid_new_id", last_id, 3);
        check_eq("mid_new_count", res_log.size(), 1);

        // Issue counter wrap after 65536 accepts.
        reset_dut();
        res_log.delete();
        req_valid = 4'b1111;
        repeat (65536) step();
        req_valid = '0;
        check_eq("wrap_issue_cnt", issue_cnt, 0);
        repeat (4) step();
        check_eq("wrap_inflight", inflight, 0);
        check_eq("wrap_results", res_log.size(), 65536);

        check_eq("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
